// File: rtl/tap_player.sv
// tap_player: captures a TAP download into block RAM and replays it as a
// pulse-width coded cassette signal (leader, sync bit, data bytes MSB first, gap).
module tap_player #(
    parameter int ADDR_W      = 16,
    parameter int HALF0       = 1500,
    parameter int HALF1       = 3000,
    parameter int LEADER_BITS = 768,
    parameter int GAP         = 100000,
    parameter int TAP_INDEX   = 1
) (
    input  logic              clock,
    input  logic              reset_osd,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              play,
    input  logic              stop,
    output logic              ear,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   tape_len,
    output logic              overflow
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LEADER, S_SYNC, S_DATA, S_GAP, S_DONE} state_t;

    localparam int MAXH = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int MAXC = (MAXH > GAP) ? MAXH : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int LW   = $clog2(LEADER_BITS + 1);
    localparam logic [CW-1:0] H0 = CW'(HALF0 - 1);
    localparam logic [CW-1:0] H1 = CW'(HALF1 - 1);
    localparam logic [CW-1:0] GL = CW'(GAP - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [LW-1:0]     lc_q, lc_d;
    logic [7:0]        sh_q, sh_d;
    logic [2:0]        bi_q, bi_d;
    logic [ADDR_W:0]   nxt_q, nxt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              ovf_q, ovf_d;
    logic              play_q;
    logic [7:0]        rd_q;
    logic [7:0]        mem [2**ADDR_W];

    logic              tap_dl, rise, playing, half_end, cur_bit, in_range, wr_en;
    logic [ADDR_W:0]   wlen;
    logic              idx_unused;

    assign idx_unused = &ioctl_index[7:6];
    assign tap_dl     = ioctl_download && (ioctl_index[5:0] == 6'(TAP_INDEX));
    assign rise       = play && !play_q;
    assign playing    = state_q inside {S_LEADER, S_SYNC, S_DATA, S_GAP};
    assign half_end   = cnt_q == '0;
    assign cur_bit    = (state_q == S_SYNC) || (state_q == S_DATA && sh_q[7]);
    assign in_range   = ioctl_addr[24:ADDR_W] == '0;
    assign wlen       = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
    assign wr_en      = state_q == S_LOAD && ioctl_wr && tap_dl && in_range;

    assign ear      = (state_q inside {S_LEADER, S_SYNC, S_DATA}) && !phase_q;
    assign busy     = playing;
    assign done     = state_q == S_DONE;
    assign tape_len = len_q;
    assign overflow = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        lc_d    = lc_q;
        sh_d    = sh_q;
        bi_d    = bi_q;
        nxt_d   = nxt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        if (playing && stop) begin
            state_d = S_IDLE;
            phase_d = 1'b0;
        end else if ((state_q == S_IDLE || playing) && tap_dl) begin
            state_d = S_LOAD;
            phase_d = 1'b0;
            len_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise && !stop) begin
                        state_d = (len_q == '0) ? S_DONE : S_LEADER;
                        cnt_d   = H0;
                        phase_d = 1'b0;
                        lc_d    = '0;
                        nxt_d   = '0;
                    end
                end
                S_LOAD: begin
                    if (!ioctl_download)
                        state_d = S_IDLE;
                    else if (ioctl_wr && tap_dl) begin
                        if (in_range)
                            len_d = (wlen > len_q) ? wlen : len_q;
                        else
                            ovf_d = 1'b1;
                    end
                end
                S_LEADER, S_SYNC, S_DATA: begin
                    if (!half_end)
                        cnt_d = cnt_q - CW'(1);
                    else if (!phase_q) begin
                        phase_d = 1'b1;
                        cnt_d   = cur_bit ? H1 : H0;
                    end else begin
                        phase_d = 1'b0;
                        if (state_q == S_LEADER) begin
                            if (lc_q == LW'(LEADER_BITS - 1)) begin
                                state_d = S_SYNC;
                                cnt_d   = H1;
                            end else begin
                                lc_d  = lc_q + LW'(1);
                                cnt_d = H0;
                            end
                        end else if (state_q == S_SYNC || bi_q == 3'd7) begin
                            // rd_q already holds byte nxt_q, fetched during the bit just sent
                            if (nxt_q == len_q) begin
                                state_d = S_GAP;
                                cnt_d   = GL;
                            end else begin
                                state_d = S_DATA;
                                sh_d    = rd_q;
                                bi_d    = '0;
                                nxt_d   = nxt_q + (ADDR_W+1)'(1);
                                cnt_d   = rd_q[7] ? H1 : H0;
                            end
                        end else begin
                            sh_d  = {sh_q[6:0], 1'b0};
                            bi_d  = bi_q + 3'd1;
                            cnt_d = sh_q[6] ? H1 : H0;
                        end
                    end
                end
                S_GAP: begin
                    if (!half_end)
                        cnt_d = cnt_q - CW'(1);
                    else
                        state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_osd) begin
        if (!reset_osd) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            lc_q    <= '0;
            sh_q    <= '0;
            bi_q    <= '0;
            nxt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            play_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            lc_q    <= lc_d;
            sh_q    <= sh_d;
            bi_q    <= bi_d;
            nxt_q   <= nxt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            play_q  <= play;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[ioctl_addr[ADDR_W-1:0]] <= ioctl_data;
        rd_q <= mem[nxt_q[ADDR_W-1:0]];
    end
endmodule

// File: doc/tap_player.md
TAP_PLAYER -- requirements
Module: tap_player

Interface
REQ-001 Parameter ADDR_W, default 16: tape buffer address width, giving 2^ADDR_W bytes of internal block RAM.
REQ-002 Parameter HALF0, default 1500: half-period of a "0" bit, in clock cycles.
REQ-003 Parameter HALF1, default 3000: half-period of a "1" bit, in clock cycles.
REQ-004 Parameter LEADER_BITS, default 768: number of leader "0" bits.
REQ-005 Parameter GAP, default 100000: trailing silence, in clock cycles.
REQ-006 Parameter TAP_INDEX, default 1: ioctl_index[5:0] value identifying a TAP download.
REQ-007 Port clock, input, 1: single system clock; all logic is on its rising edge.
REQ-008 Port reset_osd, input, 1: reset, asynchronous and active-low.
REQ-009 Port ioctl_download, input, 1: download in progress.
REQ-010 Port ioctl_index, input, 8: download file index.
REQ-011 Port ioctl_wr, input, 1: byte write strobe.
REQ-012 Port ioctl_addr, input, 25: byte address.
REQ-013 Port ioctl_data, input, 8: byte data.
REQ-014 Port play, input, 1: start-playback level; acted on at its rising edge.
REQ-015 Port stop, input, 1: abort-playback level.
REQ-016 Port ear, output, 1: cassette signal, fed to the lynx48 ear input.
REQ-017 Port busy, output, 1: high while playback is active.
REQ-018 Port done, output, 1: one-cycle pulse when playback completes normally.
REQ-019 Port tape_len, output, ADDR_W+1: number of valid bytes in the buffer.
REQ-020 Port overflow, output, 1: at least one byte of the last download was dropped.

Function
REQ-021 The block shall use states IDLE, LOAD, LEADER, SYNC, DATA, GAP, DONE.
REQ-022 State transitions:
- IDLE -> LOAD when ioctl_download=1 and ioctl_index[5:0]=TAP_INDEX.
- LOAD -> IDLE when ioctl_download falls.
- IDLE -> LEADER on a play rising edge when tape_len!=0.
- IDLE -> DONE on a play rising edge when tape_len=0.
- LEADER -> SYNC after LEADER_BITS "0" bits.
- SYNC -> DATA after one "1" bit.
- DATA -> GAP after the last bit of byte tape_len-1.
- GAP -> DONE after GAP cycles.
- DONE -> IDLE after one cycle, with done=1 for that cycle.
REQ-023 On entry to LOAD: tape_len and overflow shall clear.
REQ-024 Each ioctl_wr in LOAD with ioctl_addr < 2^ADDR_W shall write ioctl_data to RAM[ioctl_addr], and tape_len shall become max(tape_len, ioctl_addr+1).
REQ-025 Each ioctl_wr in LOAD with ioctl_addr >= 2^ADDR_W shall drop the byte and set overflow=1.
REQ-026 Bit encoding: ear=1 for HALFx cycles, then ear=0 for HALFx cycles, where x is the bit value; data bits are sent MSB first.
REQ-027 The bit stream shall be contiguous: no idle cycles between leader, sync and data bits, or between bytes.
REQ-028 Each RAM read (1-cycle latency) shall be prefetched during the preceding bit.
REQ-029 The first leader high cycle shall be the cycle after the play rising edge is sampled.
REQ-030 ear shall be 0 in IDLE, LOAD, GAP and DONE.
REQ-031 busy shall be 1 in LEADER, SYNC, DATA and GAP, and 0 otherwise.
REQ-032 stop=1 in any playback state shall force IDLE on the next cycle, with ear=0 and no done pulse.
REQ-033 When stop and a play rising edge occur in the same cycle, stop shall win.
REQ-034 ioctl_download with a matching index during playback shall abort playback to LOAD, with no done pulse.
REQ-035 A play edge during LOAD, or while busy, shall be ignored.
REQ-036 ioctl traffic with a non-matching index shall be ignored in all states.
REQ-037 The half-period counter shall be wide enough for max(HALF1, GAP) and shall reload, never wrap.

Reset
REQ-038 While reset_osd=0, the block shall asynchronously hold state=IDLE, ear=0, busy=0, done=0, tape_len=0, overflow=0, and all counters at 0.
REQ-039 Reset shall leave RAM contents undefined, but tape_len=0 makes them unreachable.
REQ-040 Reset mid-playback or mid-load shall abort immediately, with no done pulse.

Verification (bench parameters: HALF0=4, HALF1=8, LEADER_BITS=2, GAP=10, ADDR_W=4)
REQ-041 Load: index 1, byte 0xA5 written at address 0 -> tape_len=1, overflow=0.
REQ-042 Play 0xA5: play edge at cycle t -> ear waveform starts at t+1 as 0 0 1 (four zero half-periods, then sync), then 10100101. Ear is active for 128 cycles, low for 10 cycles, then done=1 at t+139 for exactly 1 cycle; busy=1 over t+1..t+138.
REQ-043 Overflow: writes at addresses 0..16 -> tape_len=16, overflow=1.
REQ-044 Empty play: play edge with tape_len=0 -> done pulse 1 cycle later, ear stays 0, busy stays 0.
REQ-045 Abort: stop asserted mid-DATA -> ear=0 and busy=0 on the next cycle, no done pulse; play and stop asserted together in IDLE -> stays IDLE.
REQ-046 Reset: reset_osd low mid-LEADER -> ear=0, busy=0 and tape_len=0 immediately (asynchronous); a later play edge -> done pulse only.
